// File: rtl/aes_pkg.sv
// Shared definitions for the sequential MixColumns block: block geometry,
// FSM state encoding and the GF(2^8) multiply-by-x helper.
package aes_pkg;

   localparam int BLOCK_W  = 128;
   localparam int COL_W    = 32;
   localparam int NUM_COLS = BLOCK_W / COL_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Valid/ready stream bundle around the MixColumns block: one 128-bit state
// going in, one transformed state coming out.
interface mix_columns_seq_if;
   import aes_pkg::*;

   logic [0:BLOCK_W-1] i_data;
   logic               i_valid;
   logic               o_ready;
   logic [0:BLOCK_W-1] o_data;
   logic               o_valid;
   logic               i_ready;

   // Producer/consumer side that drives the block.
   modport master (
      output i_data, i_valid, i_ready,
      input  o_ready, o_data, o_valid
   );

   // The block itself.
   modport slave (
      input  i_data, i_valid, i_ready,
      output o_ready, o_data, o_valid
   );

endinterface

// File: rtl/mix_column_word.sv
// Combinational MixColumns transform of a single 32-bit column.
// Byte r of the column sits at bits [8r:8r+7]; output row r is
// 2*b[r] ^ 3*b[r+1] ^ b[r+2] ^ b[r+3] with row indices taken mod 4.
module mix_column_word
   import aes_pkg::*;
(
   input  logic [0:COL_W-1] col_in,
   output logic [0:COL_W-1] col_out
);

   logic [7:0] b [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign b[gi] = col_in[8*gi +: 8];
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_row
      localparam int R1 = (gi + 1) % 4;
      localparam int R2 = (gi + 2) % 4;
      localparam int R3 = (gi + 3) % 4;
      // 3*x is folded in as xtime(x) ^ x
      assign col_out[8*gi +: 8] = xtime(b[gi]) ^ xtime(b[R1]) ^ b[R1] ^ b[R2] ^ b[R3];
   end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then presents the result
// until the consumer takes it.
module mix_columns_seq
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic [0:BLOCK_W-1] i_data,
   input  logic               i_valid,
   output logic               o_ready,
   output logic [0:BLOCK_W-1] o_data,
   output logic               o_valid,
   input  logic               i_ready
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4 (got %0d)", COLS_PER_CYCLE);
   end

   // For 4 columns per cycle the step truncates to 0: the single BUSY
   // cycle both starts and ends at column 0, so the counter never wraps.
   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] CNT_LAST = 2'(NUM_COLS - COLS_PER_CYCLE);

   state_t             state_reg;
   state_t             state_next;
   logic [1:0]         cnt_reg;
   logic [0:BLOCK_W-1] work_reg;
   logic [0:BLOCK_W-1] work_next;
   logic               armed_reg;
   logic               accept;

   logic [1:0]         col_idx [COLS_PER_CYCLE];
   logic [0:COL_W-1]   col_in  [COLS_PER_CYCLE];
   logic [0:COL_W-1]   col_out [COLS_PER_CYCLE];

   for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
      assign col_idx[gi] = cnt_reg + 2'(gi);
      assign col_in[gi]  = work_reg[{col_idx[gi], 5'b0} +: COL_W];

      mix_column_word u_word (
         .col_in  (col_in[gi]),
         .col_out (col_out[gi])
      );
   end

   // Splice the freshly transformed columns back into the working state.
   always_comb begin
      work_next = work_reg;
      for (int i = 0; i < COLS_PER_CYCLE; i++) begin
         work_next[{col_idx[i], 5'b0} +: COL_W] = col_out[i];
      end
   end

   // FSM state register.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state: accept in IDLE, finish on the column-3 write, release on i_ready.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept)              state_next = ST_BUSY;
         ST_BUSY: if (cnt_reg == CNT_LAST) state_next = ST_DONE;
         ST_DONE: if (i_ready)             state_next = ST_IDLE;
         default:                          state_next = ST_IDLE;
      endcase
   end

   // FSM outputs; armed_reg keeps o_ready low until the first edge after reset.
   always_comb begin
      o_ready = armed_reg && (state_reg == ST_IDLE);
      o_valid = (state_reg == ST_DONE);
   end

   assign accept = o_ready && i_valid;
   assign o_data = work_reg;

   // Datapath: capture on accept, transform in place while BUSY, hold otherwise.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         armed_reg <= 1'b0;
         cnt_reg   <= 2'd0;
         work_reg  <= '0;
      end else begin
         armed_reg <= 1'b1;
         if (accept) begin
            work_reg <= i_data;
            cnt_reg  <= 2'd0;
         end else if (state_reg == ST_BUSY) begin
            work_reg <= work_next;
            cnt_reg  <= cnt_reg + CNT_STEP;
         end
      end
   end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Testbench for mix_columns_seq: three instances (1, 2 and 4 columns per
// cycle) checked against a GF(2^8) matrix-product reference model.
`timescale 1ns/1ps
module tb_mix_columns_seq;

   localparam int NUM_DUT    = 3;
   localparam int WAIT_LIMIT = 40;
   localparam int B2B_BLOCKS = 100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [0:127] drv_data  [NUM_DUT];
   logic         drv_valid [NUM_DUT];
   logic         drv_ready [NUM_DUT];
   logic [0:127] mon_data  [NUM_DUT];
   logic         mon_valid [NUM_DUT];
   logic         mon_ready [NUM_DUT];

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   // Instance gi runs with 1 << gi columns per cycle: 1, 2, 4.
   for (genvar gi = 0; gi < NUM_DUT; gi++) begin : g_dut
      mix_columns_seq_if bus ();

      assign bus.i_data    = drv_data[gi];
      assign bus.i_valid   = drv_valid[gi];
      assign bus.i_ready   = drv_ready[gi];
      assign mon_data[gi]  = bus.o_data;
      assign mon_valid[gi] = bus.o_valid;
      assign mon_ready[gi] = bus.o_ready;

      mix_columns_seq #(.COLS_PER_CYCLE(1 << gi)) dut (
         .i_clock   (clk),
         .i_reset_n (rst_n),
         .i_data    (bus.i_data),
         .i_valid   (bus.i_valid),
         .o_ready   (bus.o_ready),
         .o_data    (bus.o_data),
         .o_valid   (bus.o_valid),
         .i_ready   (bus.i_ready)
      );
   end

   // ---------------- reference model ----------------
   // Carry-less product followed by reduction modulo 0x11B.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      prod = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) prod = prod ^ (16'(a) << i);
      end
      for (int i = 15; i >= 8; i--) begin
         if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
      end
      return prod[7:0];
   endfunction

   // First row of the circulant MixColumns matrix: 2 3 1 1.
   function automatic logic [7:0] mix_coef(input int d);
      case (d)
         0:       return 8'h02;
         1:       return 8'h03;
         default: return 8'h01;
      endcase
   endfunction

   function automatic logic [0:127] ref_mix(input logic [0:127] s);
      logic [0:127] r;
      logic [7:0]   acc;
      logic [7:0]   bk;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
               bk  = s[8*(4*c + k) +: 8];
               acc = acc ^ gf_mul(mix_coef((k - row + 4) % 4), bk);
            end
            r[8*(4*c + row) +: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic logic [0:127] rand_block();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Waits (bounded) for o_ready, then presents one block for one edge.
   task automatic push(input int d, input logic [0:127] din);
      int n;
      n = 0;
      while (!mon_ready[d] && n < WAIT_LIMIT) begin
         tick();
         n++;
      end
      drv_data[d]  = din;
      drv_valid[d] = 1'b1;
      tick();
      drv_valid[d] = 1'b0;
   endtask

   // Counts cycles until o_valid; returns WAIT_LIMIT on timeout.
   task automatic wait_valid(input int d, output int lat);
      lat = 0;
      while (!mon_valid[d] && lat < WAIT_LIMIT) begin
         tick();
         lat++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      repeat (3) tick();
      for (int d = 0; d < NUM_DUT; d++) begin
         tests_run++;
         if (mon_ready[d] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready dut%0d: got %b expected 0", d, mon_ready[d]);
         end
         tests_run++;
         if (mon_valid[d] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid dut%0d: got %b expected 0", d, mon_valid[d]);
         end
         tests_run++;
         if (mon_data[d] !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_data dut%0d: got %h expected 0", d, mon_data[d]);
         end
      end
      rst_n = 1'b1;
      tick();
      for (int d = 0; d < NUM_DUT; d++) begin
         tests_run++;
         if (mon_ready[d] !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_ready dut%0d: got %b expected 1", d, mon_ready[d]);
         end
      end
      $display("[TB] reset released, all instances checked");
   endtask

   task automatic test_known_vectors();
      logic [0:127] vin  [4];
      logic [0:127] vexp [4];
      int           vdut [4];
      int           d;
      int           lat;
      vin[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      vexp[0] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      vdut[0] = 0;
      for (int t = 1; t < 4; t++) begin
         vin[t]  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
         vexp[t] = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
      end
      vdut[1] = 2;
      vdut[2] = 1;
      vdut[3] = 0;
      for (int t = 0; t < 4; t++) begin
         d = vdut[t];
         push(d, vin[t]);
         wait_valid(d, lat);
         tests_run++;
         if (lat !== (4 >> d)) begin
            tests_failed++;
            $display("FAIL vec%0d_latency dut%0d: got %0d expected %0d", t, d, lat, 4 >> d);
         end
         tests_run++;
         if (mon_data[d] !== vexp[t]) begin
            tests_failed++;
            $display("FAIL vec%0d_data dut%0d: got %h expected %h", t, d, mon_data[d], vexp[t]);
         end
         tests_run++;
         if (mon_ready[d] !== 1'b0) begin
            tests_failed++;
            $display("FAIL vec%0d_ready_done dut%0d: got %b expected 0", t, d, mon_ready[d]);
         end
         $display("[TB] vec%0d dut%0d in=%h out=%h lat=%0d", t, d, vin[t], mon_data[d], lat);
         drv_ready[d] = 1'b1;
         tick();
         drv_ready[d] = 1'b0;
         tests_run++;
         if (mon_valid[d] !== 1'b0 || mon_ready[d] !== 1'b1) begin
            tests_failed++;
            $display("FAIL vec%0d_release dut%0d: got valid=%b ready=%b expected valid=0 ready=1",
                     t, d, mon_valid[d], mon_ready[d]);
         end
      end
   endtask

   task automatic test_stall_hold();
      logic [0:127] din;
      logic [0:127] expv;
      int           lat;
      din  = rand_block();
      expv = ref_mix(din);
      push(0, din);
      wait_valid(0, lat);
      tests_run++;
      if (lat !== 4 || mon_data[0] !== expv) begin
         tests_failed++;
         $display("FAIL stall_first lat=%0d data=%h expected lat=4 data=%h", lat, mon_data[0], expv);
      end
      for (int c = 0; c < 5; c++) begin
         drv_ready[0] = 1'b0;
         tick();
         tests_run++;
         if (mon_valid[0] !== 1'b1 || mon_ready[0] !== 1'b0 || mon_data[0] !== expv) begin
            tests_failed++;
            $display("FAIL stall_hold cycle%0d: got valid=%b ready=%b data=%h expected 1 0 %h",
                     c, mon_valid[0], mon_ready[0], mon_data[0], expv);
         end
      end
      drv_ready[0] = 1'b1;
      tick();
      drv_ready[0] = 1'b0;
      tests_run++;
      if (mon_ready[0] !== 1'b1 || mon_valid[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_release: got ready=%b valid=%b expected 1 0", mon_ready[0], mon_valid[0]);
      end
      repeat (2) tick();
      tests_run++;
      if (mon_data[0] !== expv) begin
         tests_failed++;
         $display("FAIL idle_hold_data: got %h expected %h", mon_data[0], expv);
      end
      $display("[TB] stall in=%h out=%h held 5 cycles", din, expv);
   endtask

   task automatic test_ignore_valid();
      logic [0:127] blk_a;
      logic [0:127] blk_b;
      logic [0:127] expv;
      int           lat;
      blk_a = rand_block();
      blk_b = rand_block();
      expv  = ref_mix(blk_a);
      push(0, blk_a);
      tick();
      drv_data[0]  = blk_b;
      drv_valid[0] = 1'b1;
      repeat (2) tick();
      drv_valid[0] = 1'b0;
      wait_valid(0, lat);
      tests_run++;
      if (lat + 3 !== 4) begin
         tests_failed++;
         $display("FAIL ignore_latency: got %0d expected 4", lat + 3);
      end
      tests_run++;
      if (mon_data[0] !== expv) begin
         tests_failed++;
         $display("FAIL ignore_data: got %h expected %h", mon_data[0], expv);
      end
      drv_valid[0] = 1'b1;
      repeat (2) tick();
      drv_valid[0] = 1'b0;
      tests_run++;
      if (mon_valid[0] !== 1'b1 || mon_data[0] !== expv) begin
         tests_failed++;
         $display("FAIL ignore_in_done: got valid=%b data=%h expected 1 %h", mon_valid[0], mon_data[0], expv);
      end
      drv_ready[0] = 1'b1;
      tick();
      drv_ready[0] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tests_run++;
         if (mon_valid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_phantom cycle%0d: got valid=%b expected 0", c, mon_valid[0]);
         end
         tick();
      end
      $display("[TB] ignore in=%h out=%h", blk_a, expv);
   endtask

   task automatic test_reset_mid_block();
      logic [0:127] din;
      logic [0:127] expv;
      int           lat;
      // Reset while instance 0 is BUSY.
      push(0, rand_block());
      tick();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (mon_valid[0] !== 1'b0 || mon_data[0] !== 128'h0 || mon_ready[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL busy_reset_now: got valid=%b ready=%b data=%h expected 0 0 0",
                  mon_valid[0], mon_ready[0], mon_data[0]);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (mon_ready[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL busy_reset_ready: got %b expected 1", mon_ready[0]);
      end
      for (int c = 0; c < 5; c++) begin
         tests_run++;
         if (mon_valid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_reset_pulse cycle%0d: got valid=%b expected 0", c, mon_valid[0]);
         end
         tick();
      end
      din  = rand_block();
      expv = ref_mix(din);
      push(0, din);
      wait_valid(0, lat);
      tests_run++;
      if (lat !== 4 || mon_data[0] !== expv) begin
         tests_failed++;
         $display("FAIL busy_reset_next: got lat=%0d data=%h expected lat=4 data=%h", lat, mon_data[0], expv);
      end
      $display("[TB] after busy reset in=%h out=%h lat=%0d", din, mon_data[0], lat);
      drv_ready[0] = 1'b1;
      tick();
      drv_ready[0] = 1'b0;

      // Reset while instance 2 is DONE.
      push(2, rand_block());
      wait_valid(2, lat);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (mon_valid[2] !== 1'b0 || mon_data[2] !== 128'h0) begin
         tests_failed++;
         $display("FAIL done_reset_now: got valid=%b data=%h expected 0 0", mon_valid[2], mon_data[2]);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (mon_ready[2] !== 1'b1 || mon_valid[2] !== 1'b0) begin
         tests_failed++;
         $display("FAIL done_reset_release: got ready=%b valid=%b expected 1 0", mon_ready[2], mon_valid[2]);
      end
      $display("[TB] done-state reset on dut2 discarded block");
   endtask

   task automatic test_back_to_back();
      logic [0:127] exp_q [$];
      logic [0:127] expv;
      int           sent;
      int           got;
      int           cyc;
      logic         took;
      for (int d = 0; d < NUM_DUT; d++) begin
         exp_q.delete();
         sent = 0;
         got  = 0;
         cyc  = 0;
         drv_valid[d] = 1'b0;
         drv_ready[d] = 1'b0;
         while ((sent < B2B_BLOCKS || got < B2B_BLOCKS) && cyc < 20000) begin
            took = 1'b0;
            if (!drv_valid[d] && sent < B2B_BLOCKS && $urandom_range(3) != 0) begin
               drv_data[d]  = rand_block();
               drv_valid[d] = 1'b1;
            end
            drv_ready[d] = ($urandom_range(2) != 0);
            if (drv_valid[d] && mon_ready[d]) begin
               exp_q.push_back(ref_mix(drv_data[d]));
               sent++;
               took = 1'b1;
            end
            if (mon_valid[d] && drv_ready[d]) begin
               tests_run++;
               if (exp_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL b2b_extra dut%0d: got output %h expected none", d, mon_data[d]);
               end else begin
                  expv = exp_q.pop_front();
                  if (mon_data[d] !== expv) begin
                     tests_failed++;
                     $display("FAIL b2b_data dut%0d blk%0d: got %h expected %h", d, got, mon_data[d], expv);
                  end
                  $display("[TB] b2b dut%0d blk%0d out=%h", d, got, mon_data[d]);
               end
               got++;
            end
            tick();
            cyc++;
            if (took) drv_valid[d] = 1'b0;
         end
         drv_valid[d] = 1'b0;
         tests_run++;
         if (got !== B2B_BLOCKS || sent !== B2B_BLOCKS || exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL b2b_count dut%0d: got sent=%0d received=%0d pending=%0d expected %0d %0d 0",
                     d, sent, got, exp_q.size(), B2B_BLOCKS, B2B_BLOCKS);
         end
         drv_ready[d] = 1'b1;
         for (int c = 0; c < 6; c++) begin
            tick();
            tests_run++;
            if (mon_valid[d] !== 1'b0) begin
               tests_failed++;
               $display("FAIL b2b_trailing dut%0d: got valid=%b expected 0", d, mon_valid[d]);
            end
         end
         drv_ready[d] = 1'b0;
      end
   endtask

   initial begin
      for (int d = 0; d < NUM_DUT; d++) begin
         drv_data[d]  = '0;
         drv_valid[d] = 1'b0;
         drv_ready[d] = 1'b0;
      end
      test_reset();
      test_known_vectors();
      test_stall_hold();
      test_ignore_valid();
      test_reset_mid_block();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
